ahblsram_ahbl_slave_if: RTL and testbench

AHB-Lite slave front end for the LSRAM subsystem. Decodes AHB-Lite transfers, checks them, and issues single-pulse requests on the ahbsram_req/sramahb_ack interface to the SRAM controller. It inserts wait states until the controller acknowledges, then returns HRDATA/HRESP to the bus. It is the initiator end of the SRAM-control handshake.

---
 rtl/ahblsram_ahbl_slave_if.sv | 154 +++++++++++++++
 tb/tb_ahblsram_ahbl_slave_if.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahblsram_ahbl_slave_if.sv
// AHB-Lite slave front end for the LSRAM subsystem: decodes and checks bus transfers,
// issues single-pulse requests to the SRAM controller and returns HRDATA/HRESP.
module ahblsram_ahbl_slave_if #(
    parameter int unsigned MEM_AWIDTH = 19,
    parameter int unsigned MEM_DEPTH  = 512
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic                  ahbsram_req,
    output logic                  ahbsram_write,
    output logic [2:0]            ahbsram_size,
    output logic [MEM_AWIDTH-1:0] ahbsram_addr,
    output logic [31:0]           ahbsram_wdata,
    output logic [31:0]           ahbsram_wdata_usram,
    input  logic                  sramahb_ack,
    input  logic [31:0]           sramahb_rdata,
    input  logic                  BUSY
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StReq  = 3'd1,
        StWait = 3'd2,
        StDone = 3'd3,
        StErr1 = 3'd4,
        StErr2 = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic [2:0]            size_q, size_d;
    logic [MEM_AWIDTH-1:0] addr_q, addr_d;

    logic        accept_window;
    logic        xfer_valid;
    logic        xfer_accept;
    logic        xfer_err;
    logic [31:0] word_idx;
    state_e      accept_state;

    logic        hreadyout_c;
    logic        hresp_c;
    logic [31:0] hrdata_c;
    logic        req_c;

    // Upper address bits and HTRANS[0] carry no meaning for this slave.
    logic unused_inputs;
    assign unused_inputs = ^{HADDR[31:MEM_AWIDTH], HTRANS[0]};

    assign accept_window = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr2);
    assign xfer_valid    = HSEL & HREADY & HTRANS[1];
    assign xfer_accept   = accept_window & xfer_valid;

    assign word_idx = 32'(HADDR[MEM_AWIDTH-1:2]);

    assign xfer_err = (HSIZE > 3'd2)
                    | ((HSIZE == 3'd1) & HADDR[0])
                    | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00))
                    | (word_idx >= MEM_DEPTH);

    assign accept_state = xfer_err ? StErr1 : StReq;

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        addr_d      = addr_q;
        hreadyout_c = 1'b1;
        hresp_c     = 1'b0;
        hrdata_c    = 32'h0;
        req_c       = 1'b0;

        if (xfer_accept) begin
            write_d = HWRITE;
            size_d  = HSIZE;
            addr_d  = HADDR[MEM_AWIDTH-1:0];
        end

        case (state_q)
            StIdle: begin
                if (xfer_accept) begin
                    state_d = accept_state;
                end
            end
            StReq: begin
                hreadyout_c = 1'b0;
                req_c       = ~BUSY;
                if (!BUSY) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                hreadyout_c = 1'b0;
                if (sramahb_ack) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Controller read data arrives the cycle after ack, i.e. now.
                if (!write_q) begin
                    hrdata_c = sramahb_rdata;
                end
                state_d = xfer_accept ? accept_state : StIdle;
            end
            StErr1: begin
                hreadyout_c = 1'b0;
                hresp_c     = 1'b1;
                state_d     = StErr2;
            end
            StErr2: begin
                hresp_c = 1'b1;
                state_d = xfer_accept ? accept_state : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
        end
    end

    assign HREADYOUT           = hreadyout_c;
    assign HRESP               = hresp_c;
    assign HRDATA              = hrdata_c;
    assign ahbsram_req         = req_c;
    assign ahbsram_write       = write_q;
    assign ahbsram_size        = size_q;
    assign ahbsram_addr        = addr_q;
    assign ahbsram_wdata       = HWDATA;
    assign ahbsram_wdata_usram = HWDATA;

endmodule

// File: tb/tb_ahblsram_ahbl_slave_if.sv
// Directed self-checking bench for ahblsram_ahbl_slave_if with a one-cycle-ack
// controller responder.
module tb_ahblsram_ahbl_slave_if;

    localparam int unsigned AW    = 19;
    localparam int unsigned DEPTH = 512;

    logic          HCLK;
    logic          HRESET;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic          ahbsram_req;
    logic          ahbsram_write;
    logic [2:0]    ahbsram_size;
    logic [AW-1:0] ahbsram_addr;
    logic [31:0]   ahbsram_wdata;
    logic [31:0]   ahbsram_wdata_usram;
    logic          sramahb_ack;
    logic [31:0]   sramahb_rdata;
    logic          BUSY;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          req_cnt  = 0;
    int          busy_viol = 0;
    logic        req_now;
    logic [31:0] rd_value = 32'h0BAD_0BAD;

    ahblsram_ahbl_slave_if #(
        .MEM_AWIDTH(AW),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .HCLK               (HCLK),
        .HRESET             (HRESET),
        .HSEL               (HSEL),
        .HADDR              (HADDR),
        .HTRANS             (HTRANS),
        .HWRITE             (HWRITE),
        .HSIZE              (HSIZE),
        .HWDATA             (HWDATA),
        .HREADY             (HREADY),
        .HREADYOUT          (HREADYOUT),
        .HRESP              (HRESP),
        .HRDATA             (HRDATA),
        .ahbsram_req        (ahbsram_req),
        .ahbsram_write      (ahbsram_write),
        .ahbsram_size       (ahbsram_size),
        .ahbsram_addr       (ahbsram_addr),
        .ahbsram_wdata      (ahbsram_wdata),
        .ahbsram_wdata_usram(ahbsram_wdata_usram),
        .sramahb_ack        (sramahb_ack),
        .sramahb_rdata      (sramahb_rdata),
        .BUSY               (BUSY)
    );

    // Single-slave bus: HREADY follows this slave's own HREADYOUT.
    assign HREADY = HREADYOUT;

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Controller model: ack the cycle after req, read data valid the cycle after ack.
    initial begin
        sramahb_ack   = 1'b0;
        sramahb_rdata = 32'h0;
        forever begin
            @(negedge HCLK);
            req_now = ahbsram_req;
            if (req_now) req_cnt++;
            if (ahbsram_req && BUSY) busy_viol++;
            @(posedge HCLK);
            #1;
            if (sramahb_ack) sramahb_rdata = rd_value;
            else             sramahb_rdata = 32'hA5A5_5A5A;
            sramahb_ack = req_now && !HRESET;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_addr(input logic wr, input logic [2:0] sz, input logic [31:0] addr);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = wr;
        HSIZE  = sz;
        HADDR  = addr;
    endtask

    task automatic drive_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_idle_rdy"}, 32'(HREADYOUT), 32'd1);
        check_eq({tag, "_idle_resp"}, 32'(HRESP), 32'd0);
        check_eq({tag, "_idle_rdata"}, HRDATA, 32'h0);
    endtask

    // One isolated transfer from IDLE; busy_n cycles of BUSY at the start of the data phase.
    task automatic single(input string tag, input logic wr, input logic [2:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd, input logic err,
                          input int busy_n);
        int   cyc;
        int   req_at;
        int   r0;
        logic done;
        step();
        drive_addr(wr, sz, addr);
        HWDATA = 32'h0;
        @(negedge HCLK);
        check_eq({tag, "_addr_rdy"}, 32'(HREADYOUT), 32'd1);
        r0 = req_cnt;
        step();
        drive_idle();
        HWDATA = wd;
        BUSY   = (busy_n > 0);
        cyc    = 0;
        req_at = 0;
        done   = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge HCLK);
            cyc++;
            check_eq({tag, "_resp"}, 32'(HRESP), 32'(err));
            if (ahbsram_req) begin
                req_at = cyc;
                check_eq({tag, "_req_addr"}, 32'(ahbsram_addr), addr & 32'h0007_FFFF);
                check_eq({tag, "_req_size"}, 32'(ahbsram_size), 32'(sz));
                check_eq({tag, "_req_write"}, 32'(ahbsram_write), 32'(wr));
                check_eq({tag, "_req_wdata"}, ahbsram_wdata, wd);
                check_eq({tag, "_req_wdata_usram"}, ahbsram_wdata_usram, wd);
            end
            if (HREADYOUT) begin
                done = 1'b1;
            end else begin
                check_eq({tag, "_wait_rdata"}, HRDATA, 32'h0);
                step();
                BUSY = (cyc < busy_n);
            end
        end
        BUSY = 1'b0;
        check_eq({tag, "_completed"}, 32'(done), 32'd1);
        check_eq({tag, "_len"}, 32'(cyc), err ? 32'd2 : 32'(3 + busy_n));
        check_eq({tag, "_rdata"}, HRDATA, (wr || err) ? 32'h0 : rd_value);
        check_eq({tag, "_nreq"}, 32'(req_cnt - r0), err ? 32'd0 : 32'd1);
        if (!err) check_eq({tag, "_req_at"}, 32'(req_at), 32'(busy_n + 1));
        step();
        @(negedge HCLK);
        check_idle(tag);
    endtask

    initial begin
        int r0;
        HRESET = 1'b1;
        HSEL   = 1'b0;
        HADDR  = 32'h0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HSIZE  = 3'd0;
        HWDATA = 32'h0;
        BUSY   = 1'b0;

        // Reset values
        step();
        @(negedge HCLK);
        check_idle("reset");
        check_eq("reset_req", 32'(ahbsram_req), 32'd0);
        check_eq("reset_addr", 32'(ahbsram_addr), 32'd0);
        check_eq("reset_size", 32'(ahbsram_size), 32'd0);
        check_eq("reset_write", 32'(ahbsram_write), 32'd0);
        step();
        HRESET = 1'b0;

        // Word write then read
        rd_value = 32'h1111_2222;
        single("wr_word", 1'b1, 3'd2, 32'h0000_0010, 32'h1234_5678, 1'b0, 0);
        rd_value = 32'hCAFE_F00D;
        single("rd_word", 1'b0, 3'd2, 32'h0000_0010, 32'h0, 1'b0, 0);

        // Alignment, range and size errors
        single("err_half_unal", 1'b1, 3'd1, 32'h0000_0001, 32'hFFFF_0000, 1'b1, 0);
        single("err_range", 1'b0, 3'd2, 32'(DEPTH * 4), 32'h0, 1'b1, 0);
        single("err_size3", 1'b0, 3'd3, 32'h0000_0000, 32'h0, 1'b1, 0);

        // Last valid word, halfword and byte accesses
        rd_value = 32'h0DDB_A11E;
        single("rd_last_word", 1'b0, 3'd2, 32'(DEPTH * 4 - 4), 32'h0, 1'b0, 0);
        single("wr_half", 1'b1, 3'd1, 32'h0000_0022, 32'h0000_BEEF, 1'b0, 0);
        single("wr_byte", 1'b1, 3'd0, 32'h0000_0033, 32'h0000_00AB, 1'b0, 0);

        // BUSY for four cycles on entry to REQ
        rd_value = 32'h7654_3210;
        single("busy4", 1'b0, 3'd2, 32'h0000_0100, 32'h0, 1'b0, 4);

        // Reset asserted during WAIT
        step();
        drive_addr(1'b0, 3'd2, 32'h0000_0044);
        step();
        drive_idle();
        @(negedge HCLK);
        check_eq("rst_mid_req", 32'(ahbsram_req), 32'd1);
        step();
        @(negedge HCLK);
        check_eq("rst_mid_wait_rdy", 32'(HREADYOUT), 32'd0);
        #1;
        HRESET = 1'b1;
        #1;
        check_idle("rst_mid");
        check_eq("rst_mid_req0", 32'(ahbsram_req), 32'd0);
        check_eq("rst_mid_addr", 32'(ahbsram_addr), 32'd0);
        check_eq("rst_mid_write", 32'(ahbsram_write), 32'd0);
        check_eq("rst_mid_size", 32'(ahbsram_size), 32'd0);
        step();
        HRESET = 1'b0;
        @(negedge HCLK);
        check_idle("rst_after");
        rd_value = 32'h9ABC_DEF0;
        single("rst_recover", 1'b0, 3'd2, 32'h0000_0048, 32'h0, 1'b0, 0);

        // Back-to-back: write 0x0, read 0x4, error, then a write from ERR2
        rd_value = 32'h5566_7788;
        step();
        drive_addr(1'b1, 3'd2, 32'h0000_0000);
        @(negedge HCLK);
        r0 = req_cnt;
        step();
        drive_idle();
        HWDATA = 32'hAAAA_0001;
        @(negedge HCLK);
        check_eq("b2b_c1_req", 32'(ahbsram_req), 32'd1);
        check_eq("b2b_c1_addr", 32'(ahbsram_addr), 32'h0);
        step();
        @(negedge HCLK);
        check_eq("b2b_c2_rdy", 32'(HREADYOUT), 32'd0);
        step();
        drive_addr(1'b0, 3'd2, 32'h0000_0004);
        @(negedge HCLK);
        check_eq("b2b_c3_rdy", 32'(HREADYOUT), 32'd1);
        check_eq("b2b_c3_rdata", HRDATA, 32'h0);
        step();
        drive_idle();
        @(negedge HCLK);
        check_eq("b2b_c4_req", 32'(ahbsram_req), 32'd1);
        check_eq("b2b_c4_addr", 32'(ahbsram_addr), 32'h4);
        check_eq("b2b_c4_write", 32'(ahbsram_write), 32'd0);
        step();
        @(negedge HCLK);
        check_eq("b2b_c5_rdy", 32'(HREADYOUT), 32'd0);
        step();
        drive_addr(1'b1, 3'd2, 32'h0000_0002);
        @(negedge HCLK);
        check_eq("b2b_c6_rdy", 32'(HREADYOUT), 32'd1);
        check_eq("b2b_c6_rdata", HRDATA, 32'h5566_7788);
        check_eq("b2b_c6_resp", 32'(HRESP), 32'd0);
        step();
        drive_idle();
        @(negedge HCLK);
        check_eq("b2b_c7_rdy", 32'(HREADYOUT), 32'd0);
        check_eq("b2b_c7_resp", 32'(HRESP), 32'd1);
        check_eq("b2b_c7_req", 32'(ahbsram_req), 32'd0);
        step();
        drive_addr(1'b1, 3'd2, 32'h0000_0008);
        @(negedge HCLK);
        check_eq("b2b_c8_rdy", 32'(HREADYOUT), 32'd1);
        check_eq("b2b_c8_resp", 32'(HRESP), 32'd1);
        check_eq("b2b_nreq", 32'(req_cnt - r0), 32'd2);
        step();
        drive_idle();
        HWDATA = 32'hAAAA_0003;
        @(negedge HCLK);
        check_eq("b2b_c9_req", 32'(ahbsram_req), 32'd1);
        check_eq("b2b_c9_addr", 32'(ahbsram_addr), 32'h8);
        check_eq("b2b_c9_wdata", ahbsram_wdata, 32'hAAAA_0003);
        check_eq("b2b_c9_resp", 32'(HRESP), 32'd0);
        step();
        step();
        @(negedge HCLK);
        check_eq("b2b_c11_rdy", 32'(HREADYOUT), 32'd1);
        check_eq("b2b_c11_rdata", HRDATA, 32'h0);
        step();
        @(negedge HCLK);
        check_idle("b2b_end");

        // Unselected or IDLE transfers must not capture or request
        r0 = req_cnt;
        step();
        HSEL   = 1'b0;
        HTRANS = 2'b10;
        HADDR  = 32'h0000_0040;
        HWRITE = 1'b0;
        step();
        HSEL   = 1'b1;
        HTRANS = 2'b00;
        HADDR  = 32'h0000_0050;
        step();
        drive_idle();
        @(negedge HCLK);
        check_idle("nocap");
        check_eq("nocap_addr", 32'(ahbsram_addr), 32'h8);
        check_eq("nocap_write", 32'(ahbsram_write), 32'd1);
        check_eq("nocap_nreq", 32'(req_cnt - r0), 32'd0);

        check_eq("req_while_busy", 32'(busy_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
